// File: rtl/handshake_constant_seq_pkg.sv
// Shared definitions for table-driven handshake units: index sizing helpers,
// output-slot state encoding and packed-table entry extraction.
`ifndef HANDSHAKE_CONSTANT_SEQ_PKG_SV
`define HANDSHAKE_CONSTANT_SEQ_PKG_SV

// Entry i of a packed table whose entries are w bits wide, entry 0 in the LSBs.
`define HS_TABLE_ENTRY(tbl, i, w) tbl[(i)*(w) +: (w)]

package handshake_constant_seq_pkg;

    localparam int unsigned HS_MAX_DEPTH = 256;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A one-entry table still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        w = clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`endif

// File: rtl/handshake_oehb_slot.sv
// One-slot output buffer: registers valid and payload, accepts a new token in
// the same cycle the held one drains so a stream runs at one token per cycle.
module handshake_oehb_slot
    import handshake_constant_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    slot_state_e      state_q;
    logic [WIDTH-1:0] data_q;
    logic             load;

    assign in_ready_o = (state_q == SLOT_EMPTY) || out_ready_i;
    assign load       = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            if (load) begin
                data_q  <= in_data_i;
                state_q <= SLOT_FULL;
            end else if (out_ready_i) begin
                // Payload is kept after a drain; only the valid state clears.
                state_q <= SLOT_EMPTY;
            end
        end
    end

    assign out_valid_o = (state_q == SLOT_FULL);
    assign out_data_o  = data_q;

endmodule

// File: rtl/handshake_constant_seq.sv
// Elastic constant-sequence source: each accepted control token emits the next
// table entry through a registered output slot, with a last-entry marker.
module handshake_constant_seq
    import handshake_constant_seq_pkg::*;
#(
    parameter int unsigned                  DATA_WIDTH = 18,
    parameter int unsigned                  DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]  TABLE      = '0,
    parameter bit                           WRAP       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int unsigned      IDX_W    = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic                  accept;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] entry;
    logic [DATA_WIDTH:0]   slot_in;
    logic [DATA_WIDTH:0]   slot_out;

    assign accept  = ctrl_valid && ctrl_ready;
    assign at_last = (idx_q == LAST_IDX);

    // Only codes below DEPTH select an entry; unused codes are unreachable.
    always_comb begin
        entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                entry = `HS_TABLE_ENTRY(TABLE, i, DATA_WIDTH);
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            if (at_last) begin
                idx_d = WRAP ? '0 : idx_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign slot_in = {at_last, entry};

    handshake_oehb_slot #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_slot (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (ctrl_valid),
        .in_ready_o  (ctrl_ready),
        .in_data_i   (slot_in),
        .out_valid_o (outs_valid),
        .out_ready_i (outs_ready),
        .out_data_o  (slot_out)
    );

    assign outs      = slot_out[DATA_WIDTH-1:0];
    assign outs_last = slot_out[DATA_WIDTH];

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: four configurations driven in lockstep,
// checked by vector tables and a shared token scoreboard.
module tb_handshake_constant_seq;

    localparam int unsigned DW = 18;
    localparam int unsigned NI = 4;

    localparam logic [4*DW-1:0] TBL4 = {18'h20000, 18'h1FFFF, 18'h00001, 18'h3FC4E};
    localparam logic [DW-1:0]   TBL1 = 18'h3FC4E;
    localparam logic [3*DW-1:0] TBL3 = {18'h00333, 18'h00222, 18'h00111};

    typedef logic [NI-1:0][DW:0] sb_t;

    typedef struct {
        bit            cv;
        bit            ordy;
        bit            rdy;
        bit            vld;
        logic [DW-1:0] w_out;
        bit            w_last;
        logic [DW-1:0] s_out;
        bit            s_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ctrl_valid = 1'b0;
    logic outs_ready = 1'b0;
    logic [NI-1:0] ctrl_ready;
    logic [NI-1:0] outs_valid;
    logic [NI-1:0] outs_last;
    logic [DW-1:0] outs [NI];

    int unsigned checks = 0;
    int unsigned errors = 0;

    sb_t         sb[$];
    sb_t         hold;
    bit          m_full;
    int unsigned m_idx [NI];

    always #5 clk = ~clk;

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(4), .TABLE(TBL4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready[0]),
        .outs(outs[0]), .outs_valid(outs_valid[0]), .outs_ready(outs_ready), .outs_last(outs_last[0]));

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(4), .TABLE(TBL4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready[1]),
        .outs(outs[1]), .outs_valid(outs_valid[1]), .outs_ready(outs_ready), .outs_last(outs_last[1]));

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(1), .TABLE(TBL1), .WRAP(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready[2]),
        .outs(outs[2]), .outs_valid(outs_valid[2]), .outs_ready(outs_ready), .outs_last(outs_last[2]));

    handshake_constant_seq #(.DATA_WIDTH(DW), .DEPTH(3), .TABLE(TBL3), .WRAP(1'b1)) u_d3 (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready[3]),
        .outs(outs[3]), .outs_valid(outs_valid[3]), .outs_ready(outs_ready), .outs_last(outs_last[3]));

    function automatic int unsigned depth_of(input int unsigned inst);
        case (inst)
            2:       return 1;
            3:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit wrap_of(input int unsigned inst);
        return inst != 1;
    endfunction

    function automatic logic [DW:0] exp_entry(input int unsigned inst, input int unsigned idx);
        logic [DW-1:0] d;
        case (inst)
            0, 1: begin
                case (idx)
                    0:       d = 18'h3FC4E;
                    1:       d = 18'h00001;
                    2:       d = 18'h1FFFF;
                    default: d = 18'h20000;
                endcase
            end
            2: d = 18'h3FC4E;
            default: begin
                case (idx)
                    0:       d = 18'h00111;
                    1:       d = 18'h00222;
                    default: d = 18'h00333;
                endcase
            end
        endcase
        return {idx == depth_of(inst) - 1, d};
    endfunction

    function automatic vec_t mkv(input bit cv, input bit ordy, input bit rdy, input bit vld,
                                 input logic [DW-1:0] w_out, input bit w_last,
                                 input logic [DW-1:0] s_out, input bit s_last);
        vec_t v;
        v.cv = cv; v.ordy = ordy; v.rdy = rdy; v.vld = vld;
        v.w_out = w_out; v.w_last = w_last; v.s_out = s_out; v.s_last = s_last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        hold   = '0;
        m_full = 1'b0;
        for (int i = 0; i < int'(NI); i++) m_idx[i] = 0;
    endtask

    task automatic check_state(input string tag);
        sb_t cur;
        if (m_full && sb.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 32'(sb.size()), 32'd1);
            cur = hold;
        end else begin
            cur = m_full ? sb[0] : hold;
        end
        for (int i = 0; i < int'(NI); i++) begin
            chk($sformatf("%s valid[%0d]", tag, i), 32'(outs_valid[i]), 32'(m_full));
            chk($sformatf("%s data[%0d]", tag, i), 32'({outs_last[i], outs[i]}), 32'(cur[i]));
        end
    endtask

    // Called just after a falling edge; returns the next falling edge.
    task automatic step(input bit cv, input bit ordy, output bit rdy0);
        bit  acc;
        bit  drn;
        sb_t e;
        check_state("sb");
        ctrl_valid = cv;
        outs_ready = ordy;
        #1;
        rdy0 = ctrl_ready[0];
        for (int i = 0; i < int'(NI); i++)
            chk($sformatf("ctrl_ready[%0d]", i), 32'(ctrl_ready[i]), 32'(!m_full || ordy));
        acc = cv && (!m_full || ordy);
        drn = m_full && ordy;
        if (drn) hold = sb.pop_front();
        if (acc) begin
            for (int unsigned i = 0; i < NI; i++) begin
                e[i] = exp_entry(i, m_idx[i]);
                if (m_idx[i] == depth_of(i) - 1) m_idx[i] = wrap_of(i) ? 0 : m_idx[i];
                else m_idx[i] = m_idx[i] + 1;
            end
            sb.push_back(e);
        end
        m_full = acc || (m_full && !drn);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int unsigned cycles);
        rst        = 1'b1;
        ctrl_valid = 1'b1;
        outs_ready = 1'b0;
        model_reset();
        repeat (cycles) begin
            @(negedge clk);
            for (int i = 0; i < int'(NI); i++) begin
                chk($sformatf("reset valid[%0d]", i), 32'(outs_valid[i]), 32'd0);
                chk($sformatf("reset data[%0d]", i), 32'({outs_last[i], outs[i]}), 32'd0);
                chk($sformatf("reset ready[%0d]", i), 32'(ctrl_ready[i]), 32'd1);
            end
        end
        rst        = 1'b0;
        ctrl_valid = 1'b0;
    endtask

    task automatic run_vecs(input string tag, input vec_t vecs[$]);
        bit r;
        foreach (vecs[k]) begin
            chk($sformatf("%s[%0d] valid", tag, k), 32'(outs_valid[0]), 32'(vecs[k].vld));
            chk($sformatf("%s[%0d] wrap out", tag, k), 32'({outs_last[0], outs[0]}),
                32'({vecs[k].w_last, vecs[k].w_out}));
            chk($sformatf("%s[%0d] sat out", tag, k), 32'({outs_last[1], outs[1]}),
                32'({vecs[k].s_last, vecs[k].s_out}));
            step(vecs[k].cv, vecs[k].ordy, r);
            chk($sformatf("%s[%0d] ready", tag, k), 32'(r), 32'(vecs[k].rdy));
        end
    endtask

    initial begin
        vec_t stream[$];
        vec_t bp[$];
        bit   r;

        stream.push_back(mkv(1, 1, 1, 0, 18'h00000, 0, 18'h00000, 0));
        stream.push_back(mkv(1, 1, 1, 1, 18'h3FC4E, 0, 18'h3FC4E, 0));
        stream.push_back(mkv(1, 1, 1, 1, 18'h00001, 0, 18'h00001, 0));
        stream.push_back(mkv(1, 1, 1, 1, 18'h1FFFF, 0, 18'h1FFFF, 0));
        stream.push_back(mkv(1, 1, 1, 1, 18'h20000, 1, 18'h20000, 1));
        stream.push_back(mkv(1, 1, 1, 1, 18'h3FC4E, 0, 18'h20000, 1));
        stream.push_back(mkv(0, 1, 1, 1, 18'h00001, 0, 18'h20000, 1));
        stream.push_back(mkv(0, 1, 1, 0, 18'h00001, 0, 18'h20000, 1));

        bp.push_back(mkv(1, 0, 1, 0, 18'h00000, 0, 18'h00000, 0));
        for (int k = 0; k < 5; k++)
            bp.push_back(mkv(1, 0, 0, 1, 18'h3FC4E, 0, 18'h3FC4E, 0));
        bp.push_back(mkv(1, 1, 1, 1, 18'h3FC4E, 0, 18'h3FC4E, 0));
        bp.push_back(mkv(0, 1, 1, 1, 18'h00001, 0, 18'h00001, 0));
        bp.push_back(mkv(0, 1, 1, 0, 18'h00001, 0, 18'h00001, 0));

        apply_reset(3);
        run_vecs("stream", stream);

        apply_reset(2);
        run_vecs("backpressure", bp);

        // Buffer a token, then assert reset between clock edges.
        step(1'b1, 1'b0, r);
        step(1'b0, 1'b0, r);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("async valid[%0d]", i), 32'(outs_valid[i]), 32'd0);
            chk($sformatf("async data[%0d]", i), 32'({outs_last[i], outs[i]}), 32'd0);
        end
        model_reset();
        apply_reset(1);

        step(1'b1, 1'b1, r);
        step(1'b0, 1'b1, r);

        for (int c = 0; c < 1000; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);

        step(1'b0, 1'b1, r);
        step(1'b0, 1'b1, r);
        check_state("final");
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
